// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: instruction fetch vs data access.
// Data side wins ties; a streak counter bounds fetch starvation.
module mem_arbiter #(
   parameter int MAX_DSTREAK = 4,
   parameter int ADDR_W      = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [ADDR_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic              dwait,
   output logic [ADDR_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              ramerr
);

   typedef enum logic [1:0] {
      IDLE,
      I_ACC,
      D_ACC
   } state_t;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;
   localparam logic [3:0] MAXS      = 4'(MAX_DSTREAK);

   state_t     state, state_n;
   logic [3:0] dstreak, dstreak_n;
   logic       err_n;
   logic       dreq;
   logic       done;
   logic       fail;

   assign dreq = dREN | dWEN;
   assign done = (ramstate == RS_ACCESS);
   assign fail = (ramstate == RS_ERROR);

   assign iwait = iREN & ~((state == I_ACC) & done);
   assign dwait = dreq & ~((state == D_ACC) & done);
   assign iload = ramload;
   assign dload = ramload;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         dstreak <= '0;
         ramerr  <= 1'b0;
      end else begin
         state   <= state_n;
         dstreak <= dstreak_n;
         ramerr  <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      dstreak_n = dstreak;
      err_n     = 1'b0;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      unique case (state)
         IDLE: begin
            // a full streak hands one turn to the waiting fetch
            if (dreq && !(iREN && dstreak == MAXS)) begin
               state_n = D_ACC;
               if (!iREN)
                  dstreak_n = '0;
               else if (dstreak != MAXS)
                  dstreak_n = dstreak + 4'd1;
            end else if (iREN) begin
               state_n   = I_ACC;
               dstreak_n = '0;
            end
         end
         I_ACC: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            err_n   = iREN & fail;
            if (!iREN || done || fail)
               state_n = IDLE;
         end
         D_ACC: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            err_n    = dreq & fail;
            if (!dreq || done || fail)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
